trace_if: RTL and testbench
===========================

TRACE_IF -- requirements
Module: trace_if

Interface
REQ-001 The block SHALL have one clock, clk (input, 1 bit, rising-edge system clock), and one reset, nRst (input, 1 bit, asynchronous, active-low).
REQ-002 traceDin SHALL be an input, 4 bits wide, carrying TPIU trace port data; only bits [chunk width-1:0] are used.
REQ-003 traceClk SHALL be an input, 1 bit wide, carrying the TPIU trace clock; it is a data-qualifying signal sampled in the clk domain, not a clock.
REQ-004 width SHALL be an input, 2 bits wide, selecting port width: 0 = 1 bit, 1 = 2 bits, 3 = 4 bits, 2 = 4 bits (reserved code).
REQ-005 dvalid SHALL be an output, 1 bit wide, a one-clk-cycle strobe marking a new byte on dOut.
REQ-006 dOut SHALL be an output, 8 bits wide, carrying the last assembled trace byte.
REQ-007 sync SHALL be an output, 1 bit wide, high while the block is frame-aligned to the TPIU stream.

Function
REQ-008 traceClk and traceDin SHALL pass through the same two-flop synchronizer in clk, so both stay sample-consistent.
REQ-009 Every traceClk transition, rising or falling (DDR), SHALL be detected and SHALL capture exactly one chunk from synchronized traceDin.
REQ-010 Chunk bits SHALL be taken LSB-first: traceDin[0] is the earliest bit, and chunks fill bytes from bit 0 upward.
REQ-011 A 32-bit history register SHALL shift in each chunk so that the newest bits enter at the MSB end.
REQ-012 Sync SHALL be detected when, after any chunk capture, the history equals 32'h7FFF_FFFF (byte stream FF FF FF 7F: 31 ones then a zero).
REQ-013 On sync detection, sync SHALL go high, the byte bit-counter SHALL clear to 0, and no dvalid SHALL be produced for the completing 7F byte.
REQ-014 While sync is low, captured chunks SHALL update only the history, with no dvalid.
REQ-015 While sync is high, chunks SHALL accumulate into a byte; when 8 bits are collected, dOut SHALL load the byte and dvalid SHALL pulse high for exactly one clk cycle.
REQ-016 dvalid SHALL rise on the 4th clk rising edge after the traceClk transition that delivers the byte's final chunk.
REQ-017 dOut SHALL hold its value until the next byte is emitted.
REQ-018 A sync pattern detected while already in sync SHALL re-align: the bit-counter clears, and any partial byte is discarded.
REQ-019 Bytes completed before the re-aligning 7F SHALL still be emitted.
REQ-020 sync SHALL remain high until reset or until width changes value.
REQ-021 A change of width SHALL clear sync, the bit-counter and the history within one clk cycle.
REQ-022 traceClk high and low phases SHALL each be at least 4 clk periods, and traceDin SHALL be stable at least 3 clk periods before each traceClk transition; outside this, behaviour is unspecified.

Reset
REQ-023 While nRst is low, dvalid SHALL be 0, dOut SHALL be 8'h00, sync SHALL be 0, and the history, bit-counter and synchronizers SHALL be 0.
REQ-024 Deassertion of nRst SHALL NOT itself produce an edge detection, even if traceClk is high.

Verification
REQ-025 width=3; reset, then bytes FE 22 -> no dvalid, sync=0.
REQ-026 Continuing the same stream, FF FF FF 7F -> sync=1 after the 7F, no dvalid for any of these bytes.
REQ-027 Continuing, bytes 42 71 19 69 12 (DDR, 2 traceClk edges per byte) -> exactly five dvalid pulses with dOut = 42, 71, 19, 69, 12 in order, each pulse 1 cycle wide.
REQ-028 Repeat REQ-025..027 with width=1 (4 edges per byte) and width=0 (8 edges per byte) -> identical dOut sequence.
REQ-029 In sync, send 1 nibble then FF FF FF 7F then A5 -> partial byte discarded, re-aligned, dvalid with dOut=A5 last.
REQ-030 Assert nRst mid-byte while in sync -> outputs 0 immediately; after release, no dvalid until a new FF FF FF 7F is received.

Source files
------------

// File: rtl/trace_if.sv
// trace_if: TPIU trace port receiver. Samples the trace clock/data pair in the
// clk domain and recovers bytes once aligned to the TPIU frame sync pattern.
// Latency: dvalid rises on the 4th clk edge after the last traceClk transition of a byte.
// Backpressure: none; dvalid is a one-cycle strobe and dOut holds until the next byte.
//
// Ports:
//   clk       system clock (rising edge)
//   nRst      asynchronous active-low reset
//   traceDin  TPIU data, 1/2/4 bits used depending on width
//   traceClk  TPIU trace clock, treated as a data qualifier (both edges used)
//   width     port width select: 0 = 1 bit, 1 = 2 bits, 2/3 = 4 bits
//   dvalid    one-cycle strobe, new byte on dOut
//   dOut      last assembled trace byte
//   sync      high while frame-aligned
module trace_if (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] traceDin,
  input  logic       traceClk,
  input  logic [1:0] width,
  output logic       dvalid,
  output logic [7:0] dOut,
  output logic       sync
);

  // Full TPIU sync: FF FF FF 7F seen LSB-first, newest bits at the MSB end.
  localparam logic [31:0] SYNC_PATTERN = 32'h7FFF_FFFF;
  localparam logic [3:0]  BYTE_BITS    = 4'd8;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer. Clock and data travel through the same flops so the
  // data captured on a detected transition belongs to that transition.
  // Bit 4 carries traceClk, bits 3:0 carry traceDin.
  // ---------------------------------------------------------------------------
  logic [4:0] sync1_q;
  logic [4:0] sync2_q;
  logic       tclk_d_q;
  logic [2:0] arm_q;
  logic       edge_q;
  logic [3:0] chunk_q;
  logic [1:0] width_q;

  // arm_q fills with ones after reset release; edge detection is enabled only
  // once tclk_d_q holds a real sample, so a traceClk that is already high at
  // release is not mistaken for a transition.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      tclk_d_q <= 1'b0;
      arm_q    <= '0;
      edge_q   <= 1'b0;
      chunk_q  <= '0;
      width_q  <= '0;
    end else begin
      sync1_q  <= {traceClk, traceDin};
      sync2_q  <= sync1_q;
      tclk_d_q <= sync2_q[4];
      arm_q    <= {arm_q[1:0], 1'b1};
      // Registering the edge (and its data) adds the pipeline stage that puts
      // dvalid on the 4th clk edge after the traceClk transition.
      edge_q   <= arm_q[2] & (sync2_q[4] ^ tclk_d_q);
      chunk_q  <= sync2_q[3:0];
      width_q  <= width;
    end
  end

  logic width_chg;
  assign width_chg = (width != width_q);

  // ---------------------------------------------------------------------------
  // Chunk insertion into the history. The newest chunk enters at the MSB end,
  // so after 8 bits of a byte the complete byte sits in hist[31:24].
  // ---------------------------------------------------------------------------
  logic [31:0] hist_q;
  logic [31:0] hist_shift;
  logic [3:0]  step;

  always_comb begin
    hist_shift = hist_q;
    step       = 4'd4;
    case (width)
      2'd0: begin
        hist_shift = {chunk_q[0], hist_q[31:1]};
        step       = 4'd1;
      end
      2'd1: begin
        hist_shift = {chunk_q[1:0], hist_q[31:2]};
        step       = 4'd2;
      end
      default: begin
        // Code 2 is reserved and behaves as the 4-bit port.
        hist_shift = {chunk_q, hist_q[31:4]};
        step       = 4'd4;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Alignment FSM and byte counter.
  // bit_cnt_q always holds a multiple of the chunk width (it is cleared on any
  // width change), so bit_sum lands exactly on 8 at a byte boundary.
  // ---------------------------------------------------------------------------
  state_t      state_q;
  state_t      state_d;
  logic [3:0]  bit_cnt_q;
  logic [3:0]  bit_cnt_d;
  logic [3:0]  bit_sum;
  logic [31:0] hist_d;
  logic        pattern_hit;
  logic        emit;

  assign bit_sum     = bit_cnt_q + step;
  assign pattern_hit = (hist_shift == SYNC_PATTERN);

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    bit_cnt_d = bit_cnt_q;
    emit      = 1'b0;

    if (width_chg) begin
      // Any width change invalidates the alignment and the collected bits.
      state_d   = HUNT;
      hist_d    = '0;
      bit_cnt_d = '0;
    end else if (edge_q) begin
      hist_d = hist_shift;
      if (pattern_hit) begin
        // Align (or re-align): a partial byte is dropped and the completing
        // 7F byte of the sync pattern is never emitted.
        state_d   = LOCKED;
        bit_cnt_d = '0;
      end else if (state_q == LOCKED) begin
        if (bit_sum == BYTE_BITS) begin
          emit      = 1'b1;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_sum;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= HUNT;
      hist_q    <= '0;
      bit_cnt_q <= '0;
      dvalid    <= 1'b0;
      dOut      <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      bit_cnt_q <= bit_cnt_d;
      dvalid    <= emit;
      if (emit) begin
        dOut <= hist_shift[31:24];
      end
    end
  end

  assign sync = (state_q == LOCKED);

endmodule

// File: tb/tb_trace_if.sv
module tb_trace_if;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic [3:0] traceDin = 4'h0;
  logic       traceClk = 1'b0;
  logic [1:0] width = 2'd3;
  logic       dvalid;
  logic [7:0] dOut;
  logic       sync;

  trace_if dut (
    .clk      (clk),
    .nRst     (nRst),
    .traceDin (traceDin),
    .traceClk (traceClk),
    .width    (width),
    .dvalid   (dvalid),
    .dOut     (dOut),
    .sync     (sync)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] b;
    int         due;
  } exp_t;
  exp_t sbq[$];

  // Reference model: a bit-level view of the trace stream.
  logic [31:0] m_hist = '0;
  bit          m_sync = 1'b0;
  bit          m_bits[$];
  logic [7:0]  last_exp = 8'h00;
  logic [7:0]  last_seen = 8'h00;
  bit          prev_dv = 1'b0;

  function automatic int chunk_w(input logic [1:0] wd);
    if (wd == 2'd0) return 1;
    if (wd == 2'd1) return 2;
    return 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_hist = '0;
    m_sync = 1'b0;
    m_bits.delete();
  endtask

  // Drive one chunk: data set, held 4 cycles, then a traceClk transition,
  // then one cycle of hold before the next data change.
  task automatic send_chunk(input logic [3:0] c);
    int         w;
    logic [7:0] b;
    exp_t       e;
    w = chunk_w(width);
    @(negedge clk);
    traceDin = c;
    repeat (4) @(negedge clk);
    traceClk = ~traceClk;
    for (int i = 0; i < w; i++) begin
      m_hist = {c[i], m_hist[31:1]};
      if (m_sync) m_bits.push_back(c[i]);
    end
    if (m_hist == 32'h7FFF_FFFF) begin
      m_sync = 1'b1;
      m_bits.delete();
    end else if (m_sync && m_bits.size() >= 8) begin
      for (int i = 0; i < 8; i++) b[i] = m_bits.pop_front();
      e.b   = b;
      e.due = cyc + 4;
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask

  // Send nbits of value LSB-first; unused upper data lines carry random junk.
  task automatic send_bits(input logic [31:0] value, input int nbits);
    int         w;
    logic [3:0] c;
    w = chunk_w(width);
    for (int k = 0; k < nbits; k += w) begin
      c = 4'($urandom_range(0, 15));
      for (int i = 0; i < w; i++) c[i] = value[k + i];
      send_chunk(c);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits({24'h0, b}, 8);
  endtask

  task automatic send_sync();
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h7F);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic set_width(input logic [1:0] w);
    @(negedge clk);
    if (width != w) begin
      width = w;
      model_clear();
      @(negedge clk);
      check("sync_clear_on_width_change", {31'h0, sync}, 32'h0);
    end
  endtask

  task automatic basic_sequence(input logic [1:0] w);
    set_width(w);
    send_byte(8'hFE);
    send_byte(8'h22);
    settle();
    check("sync_low_before_pattern", {31'h0, sync}, {31'h0, m_sync});
    send_sync();
    settle();
    check("sync_high_after_pattern", {31'h0, sync}, 32'h1);
    check("no_bytes_during_sync", sbq.size(), 0);
    send_byte(8'h42);
    send_byte(8'h71);
    send_byte(8'h19);
    send_byte(8'h69);
    send_byte(8'h12);
    settle();
    check("all_bytes_drained", sbq.size(), 0);
    check("last_byte", {24'h0, last_seen}, 32'h12);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (nRst) begin
      if (dvalid) begin
        if (prev_dv) begin
          checks++;
          errors++;
          $display("FAIL dvalid_pulse_width: got 2+ cycles, expected 1");
        end
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dvalid: got dOut=%0h, expected no byte", dOut);
        end else begin
          e = sbq.pop_front();
          check("dOut_value", {24'h0, dOut}, {24'h0, e.b});
          check("dvalid_latency", cyc, e.due);
          last_exp = e.b;
        end
        last_seen = dOut;
      end else if (prev_dv) begin
        check("dOut_hold", {24'h0, dOut}, {24'h0, last_exp});
      end
    end
    prev_dv = dvalid;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rb;

    // Reset state.
    #1;
    check("reset_dvalid", {31'h0, dvalid}, 32'h0);
    check("reset_dOut", {24'h0, dOut}, 32'h0);
    check("reset_sync", {31'h0, sync}, 32'h0);
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    repeat (3) @(negedge clk);

    basic_sequence(2'd3);
    basic_sequence(2'd1);
    basic_sequence(2'd0);

    // Re-alignment while in sync: stray nibble, sync pattern, then A5.
    send_bits(32'h3, 4);
    send_sync();
    send_byte(8'hA5);
    settle();
    check("realign_drained", sbq.size(), 0);
    check("realign_last_byte", {24'h0, last_seen}, 32'hA5);
    check("realign_sync", {31'h0, sync}, 32'h1);

    // Random traffic on each width, including the reserved code.
    for (int wi = 0; wi < 4; wi++) begin
      set_width(2'(3 - wi));
      send_sync();
      for (int n = 0; n < 6; n++) begin
        rb = 8'($urandom_range(0, 255));
        send_byte(rb);
      end
      settle();
      check("random_drained", sbq.size(), 0);
      check("random_sync", {31'h0, sync}, {31'h0, m_sync});
    end

    // Reset mid-byte while in sync, with traceClk high across the release.
    set_width(2'd1);
    send_sync();
    send_byte(8'h5A);
    send_bits(32'h2, 2);
    settle();
    check("pre_reset_sync", {31'h0, sync}, 32'h1);
    @(negedge clk);
    nRst = 1'b0;
    #1;
    check("mid_reset_dvalid", {31'h0, dvalid}, 32'h0);
    check("mid_reset_dOut", {24'h0, dOut}, 32'h0);
    check("mid_reset_sync", {31'h0, sync}, 32'h0);
    model_clear();
    sbq.delete();
    last_exp = 8'h00;
    traceClk = 1'b1;
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    repeat (8) @(negedge clk);
    check("post_reset_no_sync", {31'h0, sync}, 32'h0);
    send_byte(8'h42);
    send_byte(8'hC3);
    settle();
    check("post_reset_still_hunting", {31'h0, sync}, 32'h0);
    send_sync();
    send_byte(8'h3C);
    settle();
    check("post_reset_drained", sbq.size(), 0);
    check("post_reset_last_byte", {24'h0, last_seen}, 32'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
